// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_restoring_divider                                        |
// | Description : Multi-cycle unsigned restoring divider. Divides a 2*WIDTH-bit |
// |               dividend by a WIDTH-bit divisor, one quotient bit per clock, |
// |               with valid/ready handshakes on both sides. Divide-by-zero    |
// |               and quotient-overflow cases return forced results.           |
// |               Optional macro DIV_FAST_EXCEPT_EN: exception cases skip the  |
// |               iteration phase and complete on the accepting edge.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               ovf
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH:0]     r_p;        // partial remainder, one bit wider than divisor
  logic [WIDTH-1:0]   r_q;        // quotient bits collected so far
  logic [WIDTH-1:0]   r_shift;    // low dividend half, consumed MSB first
  logic [WIDTH-1:0]   r_lo;       // untouched low dividend half for the /0 result
  logic [WIDTH-1:0]   r_dvs;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_div_zero;
  logic               w_ovf;
  logic               w_last;
  logic [WIDTH:0]     w_p_shift;
  logic               w_ge;
  logic [WIDTH:0]     w_p_next;
  logic [WIDTH-1:0]   w_q_next;

  // Exception classification of the operands currently on the input port
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = !w_div_zero && (dividend[2*WIDTH-1:WIDTH] >= divisor);

  // One restoring step: shift in the next dividend bit, compare and subtract
  // at WIDTH+1 bits so the comparison never wraps
  assign w_last    = (r_cnt == c_cnt_w'(WIDTH - 1));
  assign w_p_shift = {r_p[WIDTH-1:0], r_shift[WIDTH-1]};
  assign w_ge      = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_next  = w_ge ? (w_p_shift - {1'b0, r_dvs}) : w_p_shift;
  assign w_q_next  = WIDTH'({r_q, w_ge});

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> BUSY -> DONE -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef DIV_FAST_EXCEPT_EN
          w_state_next = (w_div_zero || w_ovf) ? ST_DONE : ST_BUSY;
`else
          w_state_next = ST_BUSY;
`endif
        end
      end
      ST_BUSY: if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p       <= '0;
      r_q       <= '0;
      r_shift   <= '0;
      r_lo      <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_p      <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            r_q      <= '0;
            r_shift  <= dividend[WIDTH-1:0];
            r_lo     <= dividend[WIDTH-1:0];
            r_dvs    <= divisor;
            r_cnt    <= '0;
            div_zero <= w_div_zero;
            ovf      <= w_ovf;
`ifdef DIV_FAST_EXCEPT_EN
            // Exceptions finish immediately, so the forced result is loaded now
            if (w_div_zero || w_ovf) begin
              quotient  <= '1;
              remainder <= w_div_zero ? dividend[WIDTH-1:0] : '0;
            end
`endif
          end
        end
        ST_BUSY: begin
          r_p     <= w_p_next;
          r_q     <= w_q_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            if (div_zero) begin
              quotient  <= '1;
              remainder <= r_lo;
            end else if (ovf) begin
              quotient  <= '1;
              remainder <= '0;
            end else begin
              quotient  <= w_q_next;
              remainder <= w_p_next[WIDTH-1:0];
            end
          end
        end
        default: ;  // DONE holds the result until it is taken
      endcase
    end
  end

endmodule
`default_nettype wire
